// File: rtl/cnt_pkg.sv
// cnt_pkg: shared FSM state encoding and default width for count_sched_ctrl.
//   CNT_W_DEF - default counter width
//   st_t      - controller states (2 bits)
package cnt_pkg;
    localparam int CNT_W_DEF = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} st_t;
endpackage

// File: rtl/count_sched_ctrl_if.sv
// count_sched_ctrl_if: control/status bundle between software strobes and count_sched_ctrl.
//   master drives start, stop, periodic, tick, load_val (and capture);
//   slave drives count, busy, tc_pulse, done, err (and cap_val).
//   capture/cap_val exist only when CNT_CAPTURE_EN is defined.
interface count_sched_ctrl_if #(parameter int W = cnt_pkg::CNT_W_DEF);
    logic         start;
    logic         stop;
    logic         periodic;
    logic         tick;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         busy;
    logic         tc_pulse;
    logic         done;
    logic         err;
`ifdef CNT_CAPTURE_EN
    logic         capture;
    logic [W-1:0] cap_val;
`endif
    modport master (
`ifdef CNT_CAPTURE_EN
        output capture,
        input  cap_val,
`endif
        output start, stop, periodic, tick, load_val,
        input  count, busy, tc_pulse, done, err
    );
    modport slave (
`ifdef CNT_CAPTURE_EN
        input  capture,
        output cap_val,
`endif
        input  start, stop, periodic, tick, load_val,
        output count, busy, tc_pulse, done, err
    );
endinterface

// File: rtl/cnt_core.sv
// cnt_core: W-bit count register with load, decrement enable and count==1 detect.
//   clk, rst - clock, async active-high reset
//   ld, d    - load d (has priority over dec)
//   dec      - decrement by one; never below zero
//   q, one   - count value, q == 1
module cnt_core #(parameter int W = cnt_pkg::CNT_W_DEF) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         dec,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         one
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (ld) q <= d;
        else if (dec && q != '0) q <= q - W'(1);
    assign one = q == W'(1);
endmodule

// File: rtl/count_sched_ctrl.sv
// count_sched_ctrl: load/count-down/terminal-count sequencer with periodic reload or one-shot stop.
//   clk, rst - clock, async active-high reset
//   bus      - count_sched_ctrl_if.slave: start/stop/periodic/tick/load_val in,
//              count/busy/tc_pulse/done/err out (all registered)
//   CNT_CAPTURE_EN adds bus.capture -> bus.cap_val snapshot of the pre-update count.
module count_sched_ctrl import cnt_pkg::*; #(parameter int W = CNT_W_DEF) (
    input logic               clk,
    input logic               rst,
    count_sched_ctrl_if.slave bus
);
    st_t          state, nstate;
    logic [W-1:0] reload, q;
    logic         mode, one, ld, dec, accept, tc_hit;
    logic         busy_r, tc_r, done_r, err_r;
    assign accept = state == ST_IDLE && bus.start && !bus.stop && bus.load_val != '0;
    // stop outranks a coincident terminal tick
    assign tc_hit = state == ST_RUN && !bus.stop && bus.tick && one;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= ST_IDLE;
            reload <= '0;
            mode   <= 1'b0;
            busy_r <= 1'b0;
            tc_r   <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= nstate;
            if (accept) begin
                reload <= bus.load_val;
                mode   <= bus.periodic;
            end
            busy_r <= nstate == ST_LOAD || nstate == ST_RUN;
            tc_r   <= tc_hit;
            done_r <= tc_hit && !mode;
            err_r  <= state == ST_IDLE && bus.start && !bus.stop && bus.load_val == '0;
        end
    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: nstate = accept ? ST_LOAD : ST_IDLE;
            ST_LOAD: nstate = bus.stop ? ST_IDLE : ST_RUN;
            ST_RUN:  nstate = bus.stop ? ST_IDLE : (tc_hit && !mode) ? ST_DONE : ST_RUN;
            default: nstate = ST_IDLE;
        endcase
    end
    // periodic terminal count reloads; one-shot terminal count decrements 1 -> 0
    always_comb begin
        ld  = (state == ST_LOAD && !bus.stop) || (tc_hit && mode);
        dec = state == ST_RUN && !bus.stop && bus.tick;
    end
    cnt_core #(.W(W)) u_core (
        .clk(clk),
        .rst(rst),
        .ld(ld),
        .dec(dec),
        .d(reload),
        .q(q),
        .one(one)
    );
`ifdef CNT_CAPTURE_EN
    logic [W-1:0] cap_r;
    always_ff @(posedge clk or posedge rst)
        if (rst) cap_r <= '0;
        else if (bus.capture) cap_r <= q;
    assign bus.cap_val = cap_r;
`endif
    assign bus.count    = q;
    assign bus.busy     = busy_r;
    assign bus.tc_pulse = tc_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;
endmodule

// File: tb/tb_count_sched_ctrl.sv
// tb_count_sched_ctrl: directed scenarios plus randomized run against a cycle-level reference model.
module tb_count_sched_ctrl;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    count_sched_ctrl_if #(.W(W)) bus();
    count_sched_ctrl #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    // reference model: phase 0 idle, 1 loading, 2 counting, 3 finishing
    int           m_ph;
    logic [W-1:0] m_cnt, m_rl;
    logic         m_md, m_tc, m_dn, m_er;
`ifdef CNT_CAPTURE_EN
    logic [W-1:0] m_cap;
`endif
    task automatic model_step();
        m_tc = 1'b0;
        m_dn = 1'b0;
        m_er = 1'b0;
        if (rst) begin
            m_ph = 0; m_cnt = '0; m_rl = '0; m_md = 1'b0;
`ifdef CNT_CAPTURE_EN
            m_cap = '0;
`endif
            return;
        end
`ifdef CNT_CAPTURE_EN
        if (bus.capture) m_cap = m_cnt;
`endif
        case (m_ph)
            0: if (bus.start && !bus.stop) begin
                if (bus.load_val == '0) m_er = 1'b1;
                else begin m_ph = 1; m_rl = bus.load_val; m_md = bus.periodic; end
            end
            1: if (bus.stop) m_ph = 0; else begin m_cnt = m_rl; m_ph = 2; end
            2: if (bus.stop) m_ph = 0;
               else if (bus.tick) begin
                   if (m_cnt == W'(1)) begin
                       m_tc = 1'b1;
                       if (m_md) m_cnt = m_rl;
                       else begin m_cnt = '0; m_dn = 1'b1; m_ph = 3; end
                   end else if (m_cnt != '0) m_cnt = m_cnt - W'(1);
               end
            default: m_ph = 0;
        endcase
    endtask
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask
    task automatic idle_in();
        bus.start = 1'b0; bus.stop = 1'b0; bus.periodic = 1'b0; bus.tick = 1'b0; bus.load_val = '0;
`ifdef CNT_CAPTURE_EN
        bus.capture = 1'b0;
`endif
    endtask
    task automatic test_reset();
        idle_in();
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({bus.count, bus.busy, bus.tc_pulse, bus.done, bus.err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {bus.count, bus.busy, bus.tc_pulse, bus.done, bus.err});
        end
        rst = 1'b0;
    endtask
    task automatic test_oneshot();
        bus.start = 1'b1; bus.load_val = 4'd3; bus.periodic = 1'b0; bus.tick = 1'b1;
        cyc();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL oneshot_load_busy got %b exp 1", bus.busy); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if ({bus.count, bus.tc_pulse, bus.done, bus.busy} !== {W'(3 - i), i == 3, i == 3, i != 3}) begin
                errors++;
                $display("FAIL oneshot_step%0d got cnt=%0d tc=%b dn=%b bsy=%b exp cnt=%0d tc=%b dn=%b bsy=%b",
                         i, bus.count, bus.tc_pulse, bus.done, bus.busy, 3 - i, i == 3, i == 3, i != 3);
            end
        end
        cyc();
        checks++;
        if ({bus.tc_pulse, bus.done, bus.busy} !== 3'b000) begin
            errors++; $display("FAIL oneshot_after got tc/dn/bsy=%b exp 000", {bus.tc_pulse, bus.done, bus.busy});
        end
        idle_in();
    endtask
    task automatic test_periodic();
        bus.start = 1'b1; bus.load_val = 4'd2; bus.periodic = 1'b1; bus.tick = 1'b1;
        cyc();
        bus.start = 1'b0; bus.periodic = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ec;
            logic et;
            cyc();
            ec = (i % 2 == 0) ? W'(2) : W'(1);
            et = i >= 2 && i % 2 == 0;
            checks++;
            if ({bus.count, bus.tc_pulse, bus.done, bus.busy} !== {ec, et, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL periodic_step%0d got cnt=%0d tc=%b dn=%b bsy=%b exp cnt=%0d tc=%b dn=0 bsy=1",
                         i, bus.count, bus.tc_pulse, bus.done, bus.busy, ec, et);
            end
        end
        bus.stop = 1'b1;
        cyc();
        checks++;
        if ({bus.count, bus.busy, bus.tc_pulse} !== {W'(1), 1'b0, 1'b0}) begin
            errors++; $display("FAIL periodic_stop got cnt=%0d bsy=%b tc=%b exp 1 0 0", bus.count, bus.busy, bus.tc_pulse);
        end
        idle_in();
    endtask
    task automatic test_tick_toggle();
        int n = 0;
        bus.start = 1'b1; bus.load_val = 4'd4;
        cyc();
        bus.start = 1'b0;
        cyc();
        checks++;
        if (bus.count !== W'(4)) begin errors++; $display("FAIL toggle_load got %0d exp 4", bus.count); end
        for (int i = 0; i < 8; i++) begin
            bus.tick = (i % 2 == 0);
            cyc();
            if (bus.tick) n++;
            checks++;
            if ({bus.count, bus.tc_pulse} !== {W'(4 - n), bus.tick && n == 4}) begin
                errors++;
                $display("FAIL toggle_step%0d got cnt=%0d tc=%b exp cnt=%0d tc=%b",
                         i, bus.count, bus.tc_pulse, 4 - n, bus.tick && n == 4);
            end
        end
        idle_in();
    endtask
    task automatic test_stop();
        bus.start = 1'b1; bus.load_val = 4'd8; bus.tick = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (4) cyc();
        checks++;
        if (bus.count !== W'(5)) begin errors++; $display("FAIL stop_pre got %0d exp 5", bus.count); end
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        checks++;
        if ({bus.count, bus.busy, bus.tc_pulse, bus.done} !== {W'(5), 3'b000}) begin
            errors++; $display("FAIL stop_hit got cnt=%0d bsy=%b tc=%b dn=%b exp 5 0 0 0", bus.count, bus.busy, bus.tc_pulse, bus.done);
        end
        repeat (2) cyc();
        checks++;
        if ({bus.count, bus.busy} !== {W'(5), 1'b0}) begin
            errors++; $display("FAIL stop_hold got cnt=%0d bsy=%b exp 5 0", bus.count, bus.busy);
        end
        bus.start = 1'b1; bus.stop = 1'b1; bus.load_val = 4'd3;
        repeat (2) cyc();
        checks++;
        if ({bus.count, bus.busy, bus.err} !== {W'(5), 2'b00}) begin
            errors++; $display("FAIL start_stop got cnt=%0d bsy=%b err=%b exp 5 0 0", bus.count, bus.busy, bus.err);
        end
        idle_in();
    endtask
    task automatic test_err_busy();
        bus.start = 1'b1; bus.load_val = '0;
        cyc();
        bus.start = 1'b0;
        checks++;
        if ({bus.err, bus.busy} !== 2'b10) begin errors++; $display("FAIL err_pulse got err/bsy=%b exp 10", {bus.err, bus.busy}); end
        cyc();
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", bus.err); end
        bus.start = 1'b1; bus.load_val = 4'd5;
        cyc();
        bus.start = 1'b0;
        cyc();
        bus.start = 1'b1; bus.load_val = 4'd2; bus.periodic = 1'b1;
        repeat (2) cyc();
        checks++;
        if ({bus.count, bus.busy, bus.err} !== {W'(5), 2'b10}) begin
            errors++; $display("FAIL busy_start got cnt=%0d bsy=%b err=%b exp 5 1 0", bus.count, bus.busy, bus.err);
        end
        bus.start = 1'b0; bus.tick = 1'b1;
        repeat (5) cyc();
        checks++;
        if ({bus.count, bus.done, bus.tc_pulse} !== {W'(0), 2'b11}) begin
            errors++; $display("FAIL busy_mode got cnt=%0d dn=%b tc=%b exp 0 1 1", bus.count, bus.done, bus.tc_pulse);
        end
        idle_in();
        cyc();
    endtask
    task automatic test_async_reset();
        bus.start = 1'b1; bus.load_val = 4'd6;
        cyc();
        bus.start = 1'b0;
        cyc();
        checks++;
        if ({bus.count, bus.busy} !== {W'(6), 1'b1}) begin
            errors++; $display("FAIL arst_pre got cnt=%0d bsy=%b exp 6 1", bus.count, bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.count, bus.busy, bus.tc_pulse, bus.done, bus.err} !== '0) begin
            errors++; $display("FAIL arst_immediate got %b exp 0", {bus.count, bus.busy, bus.tc_pulse, bus.done, bus.err});
        end
        cyc();
        rst = 1'b0;
`ifdef CNT_CAPTURE_EN
        checks++;
        if (bus.cap_val !== '0) begin errors++; $display("FAIL cap_reset got %0d exp 0", bus.cap_val); end
        bus.start = 1'b1; bus.load_val = 4'd9;
        cyc();
        bus.start = 1'b0;
        cyc();
        bus.capture = 1'b1;
        cyc();
        checks++;
        if (bus.cap_val !== W'(9)) begin errors++; $display("FAIL cap_hold got %0d exp 9", bus.cap_val); end
        bus.tick = 1'b1;
        cyc();
        checks++;
        if ({bus.cap_val, bus.count} !== {W'(9), W'(8)}) begin
            errors++; $display("FAIL cap_preupdate got cap=%0d cnt=%0d exp 9 8", bus.cap_val, bus.count);
        end
        idle_in();
        bus.stop = 1'b1;
        cyc();
`endif
        idle_in();
    endtask
    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.start    = $urandom_range(0, 3) == 0;
            bus.stop     = $urandom_range(0, 19) == 0;
            bus.tick     = $urandom_range(0, 3) != 0;
            bus.periodic = $urandom_range(0, 1) == 1;
            bus.load_val = W'($urandom_range(0, (1 << W) - 1));
`ifdef CNT_CAPTURE_EN
            bus.capture  = $urandom_range(0, 4) == 0;
`endif
            cyc();
            checks++;
            if ({bus.count, bus.busy, bus.tc_pulse, bus.done, bus.err} !==
                {m_cnt, m_ph == 1 || m_ph == 2, m_tc, m_dn, m_er}) begin
                errors++;
                $display("FAIL random%0d got cnt=%0d bsy=%b tc=%b dn=%b err=%b exp cnt=%0d bsy=%b tc=%b dn=%b err=%b",
                         i, bus.count, bus.busy, bus.tc_pulse, bus.done, bus.err,
                         m_cnt, m_ph == 1 || m_ph == 2, m_tc, m_dn, m_er);
            end
`ifdef CNT_CAPTURE_EN
            checks++;
            if (bus.cap_val !== m_cap) begin errors++; $display("FAIL random_cap%0d got %0d exp %0d", i, bus.cap_val, m_cap); end
`endif
        end
        idle_in();
    endtask
    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_tick_toggle();
        test_stop();
        test_err_busy();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
